router_input_channel: RTL and testbench
=======================================

// Module: router_input_channel
// PURPOSE
//   Receive side of the inter-router link; pairs with the upstream router's output channel.
//   Two single-flit virtual channels (vc1, vc2) are written and read on alternate polarity phases.
//   Each flit's XY route is computed on acceptance. The flit is presented to the crossbar
//   with a one-hot port request and cleared on grant.
// PARAMETERS
//   DW        64  flit width (>= 64)
//   HOP_W     4   width of each hop-count field
//   HX_LSB    52  LSB of X hop count, field [HX_LSB+HOP_W-1:HX_LSB]
//   HY_LSB    48  LSB of Y hop count, field [HY_LSB+HOP_W-1:HY_LSB]
//   XDIR_BIT  62  1 = west, 0 = east
//   YDIR_BIT  61  1 = south, 0 = north
// PORTS
//   clk        in   1   clock, all state on rising edge
//   reset      in   1   synchronous, active-high
//   polarity   in   1   global phase; 1: link writes vc1 / switch reads vc2; 0: link writes vc2 / switch reads vc1
//   send_in    in   1   upstream is driving a valid flit this cycle
//   data_in    in   DW  flit from upstream
//   ready_out  out  1   write-phase VC is empty; upstream may send
//   req        out  5   one-hot request {PE,N,S,E,W} = req[4:0], for the read-phase VC
//   data_out   out  DW  read-phase flit with the consumed hop count decremented
//   grant      in   1   crossbar accepts the flit on data_out this cycle
//   ovf_err    out  1   sticky: send_in was seen while ready_out was 0
// BEHAVIOUR
//   State per VC: vld bit, flit register, 5-bit route register.
//   - Write VC = vc1 when polarity=1, else vc2. Read VC = the other one.
//   - Write and read never target the same VC in a cycle, so accept and clear cannot conflict.
//   ready_out (combinational) = !reset & !vld[write VC].
//   Accept: send_in & ready_out at edge N.
//   - Write VC captures data_in and sets vld.
//   - Route register is loaded the same edge:
//     hop_x != 0 -> E (XDIR=0) or W (XDIR=1)
//     else hop_y != 0 -> N (YDIR=0) or S (YDIR=1)
//     else PE
//   Present (combinational): if vld[read VC], req = route[read VC] and data_out = flit[read VC].
//   - The hop field matching the route is decremented by 1: X on E/W, Y on N/S, none on PE.
//   - Otherwise req = 0 and data_out = 0.
//   Latency: a flit accepted at edge N is first requested in cycle N+1 (phase has flipped).
//   - With grant in that cycle, the VC is free at edge N+1.
//   - ready_out for that VC reasserts at cycle N+2, when the VC is the write VC again.
//   Grant: grant & (req != 0) at an edge clears vld[read VC]. grant with req = 0 is ignored.
//   Stall: with no grant, the flit and route are held.
//   - req reasserts every read phase of that VC (every other cycle).
//   - ready_out stays 0 on that VC's write phases. No reordering; there is no bypass path.
//   Violation: send_in & !ready_out leaves state unchanged (flit dropped) and sets ovf_err.
//     ovf_err clears only on reset.
//   Hop counts of 0 are never decremented; no wrap-around is possible.
//   Bits outside the hop fields pass through unmodified, including VC bit 63 and the dir bits.
//   Reset (synchronous, mid-operation included) at the edge:
//   - All vld = 0, flits = 0, routes = 0, ovf_err = 0.
//   - While reset is high: ready_out = 0, req = 0, data_out = 0.
//   Any send_in or grant in a reset cycle is ignored.
// TESTING
//   1. Reset mid-stall: vld set, reset=1 one cycle
//      -> next cycle req = 0, ready_out = 1 on either phase, ovf_err = 0.
//   2. pol=1, send_in=1, hop_x=3, XDIR=0
//      -> cycle+1 (pol=0): req = 5'b00010, data_out hop_x = 2.
//      -> grant=1 -> vc1 empty; ready_out = 1 at pol=1.
//   3. hop_x=0, hop_y=2, YDIR=1 -> req = S (5'b00100), hop_y out = 1.
//      hop_x=0, hop_y=0 -> req = PE (5'b10000), data_out = data_in exactly.
//   4. Fill vc1, hold grant=0 for 6 cycles
//      -> req toggles S/0/S each cycle, ready_out = 0 on pol=1 cycles.
//      -> Concurrent vc2 fill/grant on pol=0 flows independently.
//   5. While vc1 is full at pol=1, send_in=1 with data 0xDEAD
//      -> vc1 unchanged, ovf_err = 1 and stays set until reset.
//   6. Back-to-back traffic alternating polarity, grant always 1
//      -> one flit accepted per cycle (vc1, vc2 alternately).
//      -> Output order equals input order per VC; no flit lost.

Source files
------------

// File: rtl/router_input_channel.sv
// Receive side of the inter-router link: two single-flit virtual channels written and read
// on opposite polarity phases, with an XY route computed on acceptance.
module router_input_channel #(
  parameter int DW       = 64,
  parameter int HOP_W    = 4,
  parameter int HX_LSB   = 52,
  parameter int HY_LSB   = 48,
  parameter int XDIR_BIT = 62,
  parameter int YDIR_BIT = 61
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          polarity,
  input  logic          send_in,
  input  logic [DW-1:0] data_in,
  output logic          ready_out,
  output logic [4:0]    req,
  output logic [DW-1:0] data_out,
  input  logic          grant,
  output logic          ovf_err
);

  // One-hot request encoding {PE,N,S,E,W}
  localparam logic [4:0] RT_W  = 5'b00001;
  localparam logic [4:0] RT_E  = 5'b00010;
  localparam logic [4:0] RT_S  = 5'b00100;
  localparam logic [4:0] RT_N  = 5'b01000;
  localparam logic [4:0] RT_PE = 5'b10000;

  localparam logic [HOP_W-1:0] HOP_ONE = {{(HOP_W-1){1'b0}}, 1'b1};

  function automatic logic [4:0] route_of(input logic [DW-1:0] f);
    logic [HOP_W-1:0] hx;
    logic [HOP_W-1:0] hy;
    logic [4:0]       r;
    hx = f[HX_LSB +: HOP_W];
    hy = f[HY_LSB +: HOP_W];
    if (hx != '0)      r = f[XDIR_BIT] ? RT_W : RT_E;
    else if (hy != '0) r = f[YDIR_BIT] ? RT_S : RT_N;
    else               r = RT_PE;
    return r;
  endfunction

  // The routed hop field is always non-zero, so the decrement cannot wrap.
  function automatic logic [DW-1:0] consume_hop(input logic [DW-1:0] f, input logic [4:0] r);
    logic [DW-1:0] o;
    o = f;
    if (r == RT_E || r == RT_W)      o[HX_LSB +: HOP_W] = f[HX_LSB +: HOP_W] - HOP_ONE;
    else if (r == RT_N || r == RT_S) o[HY_LSB +: HOP_W] = f[HY_LSB +: HOP_W] - HOP_ONE;
    return o;
  endfunction

  // Index 0 is vc1, index 1 is vc2.
  logic [1:0]    vld;
  logic [DW-1:0] flit  [2];
  logic [4:0]    route [2];
  logic          wr_idx;
  logic          rd_idx;
  logic          accept;
  logic          clear;

  assign wr_idx    = ~polarity;
  assign rd_idx    = polarity;
  assign ready_out = !reset && !vld[wr_idx];
  assign accept    = send_in && ready_out;
  assign clear     = grant && (req != '0);

  always_comb begin
    req      = '0;
    data_out = '0;
    if (!reset && vld[rd_idx]) begin
      req      = route[rd_idx];
      data_out = consume_hop(flit[rd_idx], route[rd_idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld      <= '0;
      flit[0]  <= '0;
      flit[1]  <= '0;
      route[0] <= '0;
      route[1] <= '0;
      ovf_err  <= 1'b0;
    end else begin
      if (accept) begin
        vld[wr_idx]   <= 1'b1;
        flit[wr_idx]  <= data_in;
        route[wr_idx] <= route_of(data_in);
      end
      if (clear) vld[rd_idx] <= 1'b0;
      if (send_in && !ready_out) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_input_channel.sv
// Bench for router_input_channel: directed scenarios plus randomized traffic checked
// against a slot-level reference model of the two virtual channels.
module tb_router_input_channel;

  logic        clk = 1'b0;
  logic        reset, polarity, send_in, grant;
  logic [63:0] data_in;
  logic        ready_out, ovf_err;
  logic [4:0]  req;
  logic [63:0] data_out;

  router_input_channel dut (
    .clk(clk), .reset(reset), .polarity(polarity), .send_in(send_in),
    .data_in(data_in), .ready_out(ready_out), .req(req), .data_out(data_out),
    .grant(grant), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  // Reference model: one slot per VC (0 = vc1, 1 = vc2).
  bit          m_vld [2];
  logic [63:0] m_flit [2];
  bit          m_ovf;
  bit          e_ready;
  logic [4:0]  e_req;
  logic [63:0] e_dout;

  function automatic logic [4:0] exp_route(input logic [63:0] d);
    longint unsigned hx, hy;
    hx = (d >> 52) & 64'hF;
    hy = (d >> 48) & 64'hF;
    if (hx != 0) return d[62] ? 5'd1 : 5'd2;
    if (hy != 0) return d[61] ? 5'd4 : 5'd8;
    return 5'd16;
  endfunction

  function automatic logic [63:0] exp_out(input logic [63:0] d);
    logic [4:0] r;
    r = exp_route(d);
    if (r == 5'd1 || r == 5'd2) return d - (64'd1 << 52);
    if (r == 5'd4 || r == 5'd8) return d - (64'd1 << 48);
    return d;
  endfunction

  function automatic logic [63:0] mk(input int hx, input int hy, input bit xd, input bit yd);
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[55:52] = hx[3:0];
    d[51:48] = hy[3:0];
    d[62] = xd;
    d[61] = yd;
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit p, input bit s, input logic [63:0] d, input bit g);
    int w, rd;
    reset = r; polarity = p; send_in = s; data_in = d; grant = g;
    w  = p ? 0 : 1;
    rd = 1 - w;
    e_ready = !r && !m_vld[w];
    e_req   = '0;
    e_dout  = '0;
    if (!r && m_vld[rd]) begin
      e_req  = exp_route(m_flit[rd]);
      e_dout = exp_out(m_flit[rd]);
    end
    @(negedge clk);
    check("ready_out", ready_out, e_ready);
    check("req", req, e_req);
    check("data_out", data_out, e_dout);
    check("ovf_err", ovf_err, m_ovf);
  endtask

  task automatic tick();
    int w, rd;
    w  = polarity ? 0 : 1;
    rd = 1 - w;
    @(posedge clk);
    if (reset) begin
      m_vld[0] = 0; m_vld[1] = 0; m_ovf = 0;
    end else begin
      if (grant && e_req != 0) m_vld[rd] = 0;
      if (send_in && e_ready) begin
        m_vld[w] = 1; m_flit[w] = data_in; n_acc++;
      end
      if (send_in && !e_ready) m_ovf = 1;
    end
    #1;
  endtask

  logic [63:0] d, held;
  bit p;

  initial begin
    reset = 1; polarity = 1; send_in = 0; grant = 0; data_in = '0;
    m_vld[0] = 0; m_vld[1] = 0; m_ovf = 0; m_flit[0] = '0; m_flit[1] = '0;
    @(posedge clk); #1;
    drive(1, 1, 1, 64'h1234, 1); tick();
    drive(0, 1, 0, '0, 0);
    check("rst_ready_p1", ready_out, 1'b1);
    tick();

    // East route, hop_x consumed
    d = mk(3, 1, 0, 0);
    drive(0, 1, 1, d, 0); tick();
    drive(0, 0, 0, '0, 1);
    check("east_req", req, 5'b00010);
    check("east_hx", data_out[55:52], 4'd2);
    tick();
    drive(0, 1, 0, '0, 0);
    check("east_freed", ready_out, 1'b1);
    tick();

    // South route, then PE pass-through
    d = mk(0, 2, 1, 1);
    drive(0, 1, 1, d, 0); tick();
    drive(0, 0, 0, '0, 1);
    check("south_req", req, 5'b00100);
    check("south_hy", data_out[51:48], 4'd1);
    tick();
    d = mk(0, 0, 1, 0);
    drive(0, 1, 1, d, 0); tick();
    drive(0, 0, 0, '0, 1);
    check("pe_req", req, 5'b10000);
    check("pe_data", data_out, d);
    tick();

    // Stall vc1 for 6 cycles
    held = mk(0, 3, 0, 1);
    drive(0, 1, 1, held, 0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, i[0], 0, '0, 0);
      check("stall_req", req, i[0] ? 5'b00000 : 5'b00100);
      if (i[0]) check("stall_ready", ready_out, 1'b0);
      tick();
    end
    // vc2 traffic flows while vc1 stays stalled
    for (int i = 0; i < 6; i++) begin
      if (i[0]) drive(0, 1, 0, '0, 1);
      else      drive(0, 0, 1, mk(1, 0, 1, 0), 0);
      tick();
    end

    // Overflow on full vc1
    drive(0, 1, 1, 64'hDEAD, 0); tick();
    drive(0, 0, 0, '0, 0);
    check("ovf_set", ovf_err, 1'b1);
    check("ovf_keep", data_out, exp_out(held));
    tick();
    for (int i = 0; i < 3; i++) begin drive(0, i[0], 0, '0, 0); tick(); end
    drive(0, 1, 0, '0, 0);
    check("ovf_sticky", ovf_err, 1'b1);
    tick();

    // Reset mid-stall
    drive(1, 0, 1, mk(2, 2, 0, 0), 1); tick();
    drive(0, 0, 0, '0, 0);
    check("rst_req", req, 5'b0);
    check("rst_ready_p0", ready_out, 1'b1);
    check("rst_ovf", ovf_err, 1'b0);
    tick();
    drive(0, 1, 0, '0, 0);
    check("rst_ready_p1b", ready_out, 1'b1);
    tick();

    // Back-to-back traffic, grant always high
    n_acc = 0;
    p = 1;
    for (int i = 0; i < 20; i++) begin
      drive(0, p, 1, mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom, $urandom), 1);
      tick();
      p = ~p;
    end
    check("b2b_accepts", n_acc, 20);

    // Randomized traffic with occasional reset and phase hold
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) != 0) p = ~p;
      drive(($urandom_range(0, 49) == 0), p, $urandom_range(0, 1),
            mk($urandom_range(0, 2), $urandom_range(0, 2), $urandom, $urandom),
            $urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
